// File: rtl/spart_ctrl.sv
// SPART bus-side controller: register decode, baud-rate strobe generator
// with receive-frame alignment, RX byte FIFO with sticky overflow, and
// a one-shot transmit load.
module spart_ctrl #(
  parameter logic [15:0] DIV_RESET  = 16'd325,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  input  logic [7:0] db_in,
  output logic [7:0] db_out,
  input  logic [7:0] rx_data,
  input  logic       rx_rda,
  input  logic       rx_en,
  output logic       baud_clk,
  output logic [7:0] tx_data,
  output logic       tx_load,
  input  logic       tx_tbr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_t;

  state_t        state_reg, state_next;
  logic [15:0]   div_reg, div_next;
  logic [15:0]   cnt_reg, cnt_next;
  logic          rx_en_prev_reg, rda_prev_reg;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          ovf_reg;
  logic [7:0]    tx_data_reg;
  logic          tx_load_reg;

  // Bus decode; every access completes on the edge where iocs is high.
  logic sel_data_rd, sel_stat_rd, sel_data_wr, sel_dbl_wr, sel_dbh_wr;
  assign sel_data_rd = iocs &  iorw & (ioaddr == 2'b00);
  assign sel_stat_rd = iocs &  iorw & (ioaddr == 2'b01);
  assign sel_data_wr = iocs & ~iorw & (ioaddr == 2'b00);
  assign sel_dbl_wr  = iocs & ~iorw & (ioaddr == 2'b10);
  assign sel_dbh_wr  = iocs & ~iorw & (ioaddr == 2'b11);

  logic fifo_empty, fifo_full, push_req, pop_en, push_en;
  logic en_rise, cnt_zero;
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == FULL_CNT);
  // One push per frame: only the rising edge of rda counts.
  assign push_req   = rx_rda & ~rda_prev_reg;
  assign pop_en     = sel_data_rd & ~fifo_empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign push_en    = push_req & (~fifo_full | pop_en);
  assign en_rise    = rx_en & ~rx_en_prev_reg;
  assign cnt_zero   = (cnt_reg == 16'd0);

  assign baud_clk = (state_reg != IDLE) & cnt_zero;
  assign tx_data  = tx_data_reg;
  assign tx_load  = tx_load_reg;

  // Divisor value after this edge's DB_LOW/DB_HIGH writes.
  always_comb begin
    div_next = div_reg;
    if (sel_dbl_wr) div_next[7:0]  = db_in;
    if (sel_dbh_wr) div_next[15:8] = db_in;
  end

  // Next state and baud counter: half-divisor preload on frame start for
  // mid-bit sampling, full reload on each strobe or divisor write.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = div_next;
        if (en_rise) begin
          state_next = ALIGN;
          cnt_next   = div_next >> 1;
        end
      end
      ALIGN, RUN: begin
        if (sel_dbl_wr || sel_dbh_wr) cnt_next = div_next;
        else if (cnt_zero)            cnt_next = div_reg;
        else                          cnt_next = cnt_reg - 16'd1;
        if (state_reg == ALIGN) begin
          if (cnt_zero) state_next = RUN;
        end else if (!rx_en && !cnt_zero) begin
          state_next = IDLE;
          cnt_next   = div_next;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = div_next;
      end
    endcase
  end

  // State, divisor, counter and edge-detect registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      div_reg        <= DIV_RESET;
      cnt_reg        <= DIV_RESET;
      rx_en_prev_reg <= 1'b0;
      rda_prev_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      div_reg        <= div_next;
      cnt_reg        <= cnt_next;
      rx_en_prev_reg <= rx_en;
      rda_prev_reg   <= rx_rda;
    end
  end

  // FIFO storage; contents are meaningless while count is zero.
  always_ff @(posedge clk) begin
    if (push_en) fifo_mem[wr_ptr_reg] <= rx_data;
  end

  // FIFO pointers, fill count and sticky overflow (set beats clear).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_en)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (push_req && fifo_full && !pop_en) ovf_reg <= 1'b1;
      else if (sel_stat_rd)                 ovf_reg <= 1'b0;
    end
  end

  // Transmit: accept a DATA write only when the transmitter is ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_data_reg <= 8'h00;
      tx_load_reg <= 1'b0;
    end else begin
      tx_load_reg <= sel_data_wr & tx_tbr;
      if (sel_data_wr && tx_tbr) tx_data_reg <= db_in;
    end
  end

  // Read mux: FIFO head, status, or zero.
  always_comb begin
    db_out = 8'h00;
    if (sel_data_rd && !fifo_empty) db_out = fifo_mem[rd_ptr_reg];
    else if (sel_stat_rd)           db_out = {5'b0, ovf_reg, tx_tbr, ~fifo_empty};
  end

endmodule

// File: doc/spart_ctrl.md
SPART_CTRL -- requirements
Module: spart_ctrl

Interface
REQ-001 Parameters SHALL be: DIV_RESET, 16'd325, baud divisor after reset; FIFO_DEPTH, 4, RX byte FIFO entries (power of 2).
REQ-002 Ports SHALL be (name direction width meaning): clk input 1 clock; rst input 1 reset, asynchronous, active-low.
REQ-003 iocs input 1 chip select; iorw input 1 1=read, 0=write; ioaddr input 2 register select; db_in input 8 write data.
REQ-004 db_out output 8 read data; rx_data input 8 receiver byte; rx_rda input 1 receiver data-available; rx_en input 1 receiver activity.
REQ-005 baud_clk output 1 one-cycle bit-sample strobe; tx_data output 8 transmit byte; tx_load output 1 one-cycle transmit load; tx_tbr input 1 transmitter ready.

Function
REQ-006 Register map SHALL be: 00 DATA (read pops RX FIFO, write loads TX); 01 STATUS (read only); 10 DB_LOW (write); 11 DB_HIGH (write).
REQ-007 Bus accesses SHALL be single-cycle, qualified by iocs, acting on the clk edge where iocs=1.
REQ-008 db_out SHALL be combinational: DATA read -> FIFO head (8'h00 if empty); STATUS read -> {5'b0, ovf, tx_tbr, ~empty}; other addresses or iocs=0 -> 8'h00.
REQ-009 DB_LOW/DB_HIGH writes SHALL update divisor[7:0]/divisor[15:8] and force the baud counter to reload on the same edge.
REQ-010 Baud generator: 16-bit down counter; at 0 it SHALL assert baud_clk for one cycle and reload divisor, giving one strobe every divisor+1 cycles; divisor 0 -> baud_clk every cycle.
REQ-011 States SHALL be IDLE, ALIGN, RUN; the baud counter is held at divisor in IDLE and baud_clk is 0.
REQ-012 IDLE -> ALIGN on rising edge of rx_en (registered rx_en prev=0, now=1); counter loaded with divisor>>1 for mid-bit sampling.
REQ-013 ALIGN -> RUN on first baud_clk; RUN -> IDLE when rx_en=0 on a cycle with no baud_clk pending (counter != 0).
REQ-014 rx_en rising edge while in ALIGN or RUN SHALL be ignored.
REQ-015 RX FIFO push SHALL occur on rising edge of rx_rda only (one push per frame despite multi-cycle rda), capturing rx_data.
REQ-016 Push when full SHALL drop the byte, leave FIFO unchanged, and set sticky ovf.
REQ-017 ovf SHALL clear on a STATUS read; a push-when-full on the same edge SHALL leave ovf=1 (set wins).
REQ-018 DATA read when empty SHALL not change pointers; pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
REQ-019 Simultaneous push and pop SHALL be legal at any fill; when full, the pop happens first so the push succeeds with no ovf; when empty, the pushed byte is stored and the pop is ignored.
REQ-020 DATA write with tx_tbr=1 SHALL register tx_data=db_in and assert tx_load for exactly the next cycle; with tx_tbr=0 the write SHALL be dropped (no tx_load).
REQ-021 tx_data SHALL hold its last loaded value until the next accepted write.

Reset
REQ-022 On rst=0 asynchronously: state=IDLE, divisor=DIV_RESET, baud counter=DIV_RESET, baud_clk=0, tx_load=0, tx_data=8'h00, FIFO empty, ovf=0, edge-detect registers=0.
REQ-023 Reset asserted mid-frame or mid-access SHALL discard FIFO contents and any pending tx_load; no partial output after release.
REQ-024 First baud_clk after reset SHALL occur only after an rx_en rising edge.

Verification
REQ-025 Write DB_LOW=8'h09, DB_HIGH=8'h00, pulse rx_en high 100 cycles -> first baud_clk 4 cycles after the ALIGN edge, then every 10 cycles while in RUN.
REQ-026 rx_data=8'hA5 with rx_rda high 2 cycles -> exactly one push; STATUS=8'h01 (tx_tbr=0); DATA read=8'hA5, then STATUS=8'h00.
REQ-027 Five frames 8'h01..8'h05 with no reads -> FIFO holds 01..04, STATUS bit2=1; next STATUS read clears ovf; DATA reads return 01,02,03,04, then 8'h00.
REQ-028 FIFO full plus DATA read on the same edge as an rx_rda rising edge -> pop returns old head, new byte stored, ovf stays 0.
REQ-029 DATA write 8'h3C with tx_tbr=1 -> tx_data=8'h3C, tx_load high one cycle; repeat with tx_tbr=0 -> no tx_load, tx_data stays 8'h3C.
REQ-030 Assert rst in RUN with 2 bytes queued -> immediate IDLE, baud_clk=0, STATUS=8'h00 after release (tx_tbr=0).
